// File: rtl/y_collect_reg.sv
// y_collect_reg: drain-side collector for one systolic array output lane.
// Stores a result stream in arrival order, then holds it for indexed reads.
module y_collect_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] DIN,
  input  logic             IN_LAST,
  output logic             IN_READY,
  input  logic             RD,
  input  logic [IDXW-1:0]  IDX,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic [IDXW:0]    COUNT,
  output logic             DONE,
  input  logic             RELEASE
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [IDXW:0] LAST_SLOT = (IDXW+1)'(DEPTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] pipe [DEPTH];
  logic             accept;
  logic             rd_ok;
  logic             in_range;

  assign IN_READY = RSTN && EN && (state == FILL);
  assign accept   = IN_VALID && IN_READY;
  assign DONE     = (state == HOLD);
  assign rd_ok    = EN && RD && (state == HOLD);
  assign in_range = {1'b0, IDX} < COUNT;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= FILL;
      COUNT <= '0;
    end else if (EN) begin
      // release beats a same-cycle accept, dropping the word
      if (RELEASE) begin
        state <= FILL;
        COUNT <= '0;
      end else if (accept) begin
        COUNT <= COUNT + 1'b1;
        if (IN_LAST || COUNT == LAST_SLOT)
          state <= HOLD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else if (EN) begin
      if (RELEASE) begin
        for (int i = 0; i < DEPTH; i++)
          pipe[i] <= '0;
      end else if (accept) begin
        pipe[COUNT[IDXW-1:0]] <= DIN;
      end
    end
  end

  // reads see pre-clear contents when paired with release
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
    end else begin
      DOUT_VALID <= rd_ok;
      if (rd_ok)
        DOUT <= in_range ? pipe[IDX] : '0;
    end
  end

endmodule

// File: doc/y_collect_reg.md
# y_collect_reg

Output-side collector for the systolic array, the drain end of the per-lane operand register path. The input side loads operands by index and streams them into the array one word per cycle. This block accepts a result stream from one array output lane and stores it in arrival order. Once the stream completes, it freezes and lets the host read any word back by absolute index.

## Interface

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 32, number of storage slots; must be a power of two.
- IDXW, 5, index width, equal to log2(DEPTH).

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RSTN  in  1  reset; one clock, asynchronous assert, active-low.
- EN  in  1  global enable; when low, all state is frozen.
- IN_VALID  in  1  a stream word is present on DIN.
- DIN  in  WIDTH  stream data from the array lane.
- IN_LAST  in  1  marks the final word of a stream; qualified by IN_VALID.
- IN_READY  out  1  collector can accept a word this cycle.
- RD  in  1  read request, honoured in HOLD only.
- IDX  in  IDXW  absolute read slot; slot 0 holds the first word received.
- DOUT  out  WIDTH  registered read data.
- DOUT_VALID  out  1  one-cycle pulse; DOUT carries the requested word.
- COUNT  out  IDXW+1  number of words stored, 0..DEPTH.
- DONE  out  1  high while in HOLD.
- RELEASE  in  1  discard the contents and re-arm for the next stream.

## Operation

- Storage is PIPE[0..DEPTH-1] plus a fill counter COUNT.
- The state machine has two states, FILL and HOLD. DONE = (state == HOLD).
- IN_READY = RSTN && EN && (state == FILL). This is combinational.
- Accept condition: EN && IN_VALID && IN_READY.
- On accept: PIPE[COUNT] <= DIN and COUNT <= COUNT+1.
- FILL -> HOLD on an accept where IN_LAST = 1, or where the new COUNT equals DEPTH.
- IN_LAST on the first word is legal and gives COUNT = 1.
- While IN_READY = 0, IN_VALID is ignored. DIN is never captured in HOLD, so no overwrite is possible.
- Read, when EN && RD && HOLD:
  - DOUT <= PIPE[IDX] if IDX < COUNT, else 0.
  - DOUT_VALID <= 1.
- Otherwise DOUT_VALID <= 0 and DOUT holds its previous value.
- RD during FILL is ignored, so DOUT_VALID stays 0.
- RELEASE, when EN is high:
  - all PIPE slots <= 0, COUNT <= 0, state <= FILL.
  - Legal in either state. In FILL it aborts a partial stream.
- RD and RELEASE in the same HOLD cycle: the read returns the pre-clear contents, then the clear takes effect.
- RELEASE and an accept in the same FILL cycle: RELEASE wins and the word is dropped.
- EN low: no accept, no read, no release. DOUT_VALID <= 0. PIPE, COUNT, state and DOUT hold.
- Reset (RSTN low, asynchronous): state FILL, COUNT 0, all PIPE slots 0, DOUT 0, DOUT_VALID 0, DONE 0, IN_READY 0.
- Reset mid-stream or mid-read discards everything with no partial completion.

## Timing

- Write: accept at cycle N -> slot and COUNT updated at N+1.
- DONE rises at N+1 after the terminating accept. IN_READY falls in the same cycle.
- Read latency is 1: RD at cycle N -> DOUT and DOUT_VALID at N+1. Back-to-back reads give one word per cycle.
- RELEASE at cycle N -> DONE 0, COUNT 0 and IN_READY 1 (if EN) at N+1. The first word of the next stream can be accepted at N+1.
- Peak throughput: DEPTH words in DEPTH consecutive cycles with no bubbles.
- Asynchronous reset takes effect immediately. Release of reset is synchronous to CLK.

## Test plan

- Full stream: EN = 1, 32 consecutive valid words 0x0100..0x011F with IN_LAST = 0 -> DONE = 1 the cycle after the 32nd word, COUNT = 32, IN_READY = 0. Reads at IDX 0, 31, 17 return 0x0100, 0x011F, 0x0111, each one cycle later with a DOUT_VALID pulse.
- Short stream: 5 words 0xA000..0xA004, IN_LAST on the 5th -> COUNT = 5, DONE = 1. RD IDX 4 returns 0xA004; RD IDX 5 returns 0x0000 with DOUT_VALID = 1.
- Overflow guard: in HOLD, drive IN_VALID with 0xDEAD for 3 cycles -> IN_READY = 0 and COUNT unchanged. Re-reading every slot matches the original data.
- Release and reuse: RD IDX 2 together with RELEASE in HOLD -> the pre-clear value is returned. Next cycle DONE = 0, COUNT = 0, IN_READY = 1. A new 3-word stream lands in slots 0..2, and RD IDX 3 returns 0.
- Enable freeze: drop EN for 4 cycles mid-stream and mid-read -> no accepts, DOUT_VALID = 0, COUNT and DOUT held. The stream resumes into the correct slot when EN returns.
- Asynchronous reset: assert RSTN = 0 mid-stream at COUNT = 12, between clock edges -> COUNT, DONE, DOUT and DOUT_VALID read 0 immediately. After reset is released, a fresh stream starts at slot 0 and all stale slots read 0.
